// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK/16 stop bits, paced by 16x s_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // The tick counter must reach SB_TICK-1 in STOP, so it widens beyond 4 bits for 2 stop bits.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   s_cnt_reg, s_cnt_next;
    logic [NW-1:0]   n_cnt_reg, n_cnt_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            tx_reg, tx_next;
    logic            done_reg, done_next;
`ifdef UART_TX_PARITY_EN
    logic            parity_reg, parity_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            s_cnt_reg  <= '0;
            n_cnt_reg  <= '0;
            b_reg      <= '0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            s_cnt_reg  <= s_cnt_next;
            n_cnt_reg  <= n_cnt_next;
            b_reg      <= b_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        s_cnt_next  = s_cnt_reg;
        n_cnt_next  = n_cnt_reg;
        b_next      = b_reg;
        done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    state_next  = START;
                    s_cnt_next  = '0;
                    b_next      = din;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^din;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_BIT_LAST) begin
                        state_next = DATA;
                        s_cnt_next = '0;
                        n_cnt_next = '0;
                    end else begin
                        s_cnt_next = s_cnt_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_BIT_LAST) begin
                        s_cnt_next = '0;
                        b_next     = b_reg >> 1;
                        if (n_cnt_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_cnt_next = n_cnt_reg + 1'b1;
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_BIT_LAST) begin
                        state_next = STOP;
                        s_cnt_next = '0;
                    end else begin
                        s_cnt_next = s_cnt_reg + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_reg == S_STOP_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_cnt_next = s_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line value is decoded from the next state so tx changes on the same edge as the state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign tx           = tx_reg;
    assign tx_busy      = (state_reg != IDLE);
    assign tx_done_tick = done_reg;

endmodule
